// File: rtl/flex_counter_pkg.sv
// flex_counter_pkg: shared types and default sizing for the flex counter bank.
package flex_counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_t;

  localparam int DEF_CNT_BITS = 8;
  localparam int DEF_NUM_CH   = 4;

endpackage

// File: rtl/flex_counter_ch.sv
// flex_counter_ch: one programmable counter channel with level flag and step pulse.
// Down counting is only built when FLEX_CNT_DOWN_EN is defined; otherwise dir is ignored.
module flex_counter_ch
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = DEF_CNT_BITS
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    count_enable,
  input  logic                    clear,
  input  logic                    dir,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    rollover_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] next_count;
  logic [NUM_CNT_BITS-1:0] up_count;
  logic [NUM_CNT_BITS-1:0] terminal;
  logic                    chan_active;
  logic                    hit;
  logic                    next_flag;
  logic                    next_pulse;

`ifdef FLEX_CNT_DOWN_EN
  logic                    down_mode;
  logic [NUM_CNT_BITS-1:0] down_count;
`else
  logic                    unused_dir;
  assign unused_dir = dir;
`endif

  // Next-state selection: clear beats load beats a count step; R == 0 parks the channel.
  always_comb begin
    chan_active = |rollover_val;
    up_count    = (count_out == rollover_val) ? ONE : count_out + ONE;
    terminal    = rollover_val;
`ifdef FLEX_CNT_DOWN_EN
    down_mode   = (cnt_dir_t'(dir) == DIR_DOWN);
    down_count  = (count_out <= ONE) ? rollover_val : count_out - ONE;
    if (down_mode) terminal = ONE;
`endif
    next_count = count_out;
    if (clear) begin
      next_count = '0;
    end else if (load) begin
      next_count = load_val;
    end else if (count_enable && chan_active) begin
`ifdef FLEX_CNT_DOWN_EN
      next_count = down_mode ? down_count : up_count;
`else
      next_count = up_count;
`endif
    end
    hit        = chan_active && (next_count == terminal);
    next_flag  = !clear && hit;
    next_pulse = !clear && !load && count_enable && hit;
  end

  // Register count, flag and pulse so every output comes straight from a flop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out      <= '0;
      rollover_flag  <= 1'b0;
      rollover_pulse <= 1'b0;
    end else begin
      count_out      <= next_count;
      rollover_flag  <= next_flag;
      rollover_pulse <= next_pulse;
    end
  end

endmodule

// File: rtl/flex_counter_multi.sv
// flex_counter_multi: bank of NUM_CH independent flex counters sharing one clock.
// Build with FLEX_CNT_DOWN_EN defined to honour the per-channel dir input.
module flex_counter_multi
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = DEF_CNT_BITS,
  parameter int NUM_CH       = DEF_NUM_CH
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              dir,
  input  logic [NUM_CH-1:0]              load,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic [NUM_CH-1:0]              rollover_pulse,
  output logic                           any_rollover
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    flex_counter_ch #(
      .NUM_CNT_BITS(NUM_CNT_BITS)
    ) u_ch (
      .clk           (clk),
      .n_rst         (n_rst),
      .count_enable  (count_enable[i]),
      .clear         (clear[i]),
      .dir           (dir[i]),
      .load          (load[i]),
      .load_val      (load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .rollover_val  (rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .count_out     (count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .rollover_flag (rollover_flag[i]),
      .rollover_pulse(rollover_pulse[i])
    );
  end

  assign any_rollover = |rollover_pulse;

endmodule

// File: tb/tb_flex_counter_multi.sv
// tb_flex_counter_multi: directed vectors with a queue-based scoreboard for flex_counter_multi.
// Down-mode expectations follow FLEX_CNT_DOWN_EN, matching the build of the DUT.
module tb_flex_counter_multi;

  localparam int W  = 4;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [CH-1:0]   count_enable;
  logic [CH-1:0]   clear;
  logic [CH-1:0]   dir;
  logic [CH-1:0]   load;
  logic [CH*W-1:0] load_val;
  logic [CH*W-1:0] rollover_val;
  logic [CH*W-1:0] count_out;
  logic [CH-1:0]   rollover_flag;
  logic [CH-1:0]   rollover_pulse;
  logic            any_rollover;

  typedef struct {
    int           tag;
    int           ch;
    logic [W-1:0] cnt;
    logic         flg;
    logic         pls;
    logic         any;
  } exp_t;

  exp_t sb[$];
  int   edges = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  flex_counter_multi #(
    .NUM_CNT_BITS(W),
    .NUM_CH      (CH)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .count_enable  (count_enable),
    .clear         (clear),
    .dir           (dir),
    .load          (load),
    .load_val      (load_val),
    .rollover_val  (rollover_val),
    .count_out     (count_out),
    .rollover_flag (rollover_flag),
    .rollover_pulse(rollover_pulse),
    .any_rollover  (any_rollover)
  );

  // Count rising edges so queued expectations can be tied to a specific edge.
  always @(posedge clk) edges <= edges + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int ch, input logic en, input logic clr, input logic dr,
                                input logic ld, input logic [W-1:0] lv, input logic [W-1:0] rv);
    count_enable[ch]       = en;
    clear[ch]              = clr;
    dir[ch]                = dr;
    load[ch]               = ld;
    load_val[ch*W +: W]    = lv;
    rollover_val[ch*W +: W] = rv;
  endtask

  task automatic expect_ch(input int ch, input int cnt, input logic flg, input logic pls, input logic any);
    exp_t e;
    e.tag = edges + 1;
    e.ch  = ch;
    e.cnt = W'(cnt);
    e.flg = flg;
    e.pls = pls;
    e.any = any;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: shortly after each rising edge, compare the DUT against every expectation due now.
  always @(posedge clk) begin
    exp_t e;
    #1;
    while (sb.size() > 0 && sb[0].tag <= edges) begin
      e = sb.pop_front();
      if (e.tag < edges) begin
        check_output($sformatf("ch%0d late expectation", e.ch), edges, e.tag);
      end else begin
        check_output($sformatf("ch%0d count @%0d", e.ch, e.tag), count_out[e.ch*W +: W], e.cnt);
        check_output($sformatf("ch%0d flag @%0d", e.ch, e.tag), rollover_flag[e.ch], e.flg);
        check_output($sformatf("ch%0d pulse @%0d", e.ch, e.tag), rollover_pulse[e.ch], e.pls);
        check_output($sformatf("any_rollover @%0d", e.tag), any_rollover, e.any);
      end
    end
  end

  // Watchdog so a stuck run still reports and stops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus; each expectation is pushed before the edge it describes.
  initial begin
    int up_seq [10];
    int dn_seq [6];
    int term;
    int last;
    up_seq = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5};

    n_rst        = 1'b1;
    count_enable = '0;
    clear        = '0;
    dir          = '0;
    load         = '0;
    load_val     = '0;
    rollover_val = '0;
    #1 n_rst = 1'b0;
    #1;
    check_output("reset count_out", count_out, 0);
    check_output("reset flag", rollover_flag, 0);
    check_output("reset pulse", rollover_pulse, 0);
    check_output("reset any", any_rollover, 0);
    tick();
    n_rst = 1'b1;

    // Up count on ch0 with R = 5.
    apply_stimulus(0, 1, 0, 0, 0, 0, 5);
    for (int i = 0; i < 10; i++) begin
      expect_ch(0, up_seq[i], up_seq[i] == 5, up_seq[i] == 5, up_seq[i] == 5);
      tick();
    end

    // Enable dropped at terminal: hold, flag stays, pulse gone.
    apply_stimulus(0, 0, 0, 0, 0, 0, 5);
    expect_ch(0, 5, 1, 0, 0);
    tick();
    expect_ch(0, 5, 1, 0, 0);
    tick();

    // Lower R below the held count: flag clears.
    apply_stimulus(0, 0, 0, 0, 0, 0, 3);
    expect_ch(0, 5, 0, 0, 0);
    tick();

    // Re-enable: run up through the wrap to the new terminal.
    apply_stimulus(0, 1, 0, 0, 0, 0, 3);
    for (int i = 0; i < 14; i++) begin
      last = (6 + i) % 16;
      expect_ch(0, last, last == 3, last == 3, last == 3);
      tick();
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 3);
    expect_ch(0, 3, 1, 0, 0);
    tick();

    // Priority: clear first, count to 2, then clear+load+enable, then load+enable.
    apply_stimulus(0, 0, 1, 0, 0, 0, 9);
    expect_ch(0, 0, 0, 0, 0);
    tick();
    apply_stimulus(0, 1, 0, 0, 0, 0, 9);
    expect_ch(0, 1, 0, 0, 0);
    tick();
    expect_ch(0, 2, 0, 0, 0);
    tick();
    apply_stimulus(0, 1, 1, 0, 1, 9, 9);
    expect_ch(0, 0, 0, 0, 0);
    tick();
    apply_stimulus(0, 1, 0, 0, 1, 9, 9);
    expect_ch(0, 9, 1, 0, 0);
    tick();
    apply_stimulus(0, 1, 0, 0, 0, 9, 9);
    expect_ch(0, 1, 0, 0, 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 9, 9);

    // ch1 disabled by R = 0 while ch2 (R = 2) counts alongside.
    apply_stimulus(1, 1, 0, 0, 0, 0, 0);
    apply_stimulus(2, 1, 0, 0, 0, 0, 2);
    for (int i = 0; i < 4; i++) begin
      last = (i % 2 == 0) ? 1 : 2;
      expect_ch(1, 0, 0, 0, last == 2);
      expect_ch(2, last, last == 2, last == 2, last == 2);
      tick();
    end
    apply_stimulus(1, 1, 0, 0, 1, 7, 0);
    expect_ch(1, 7, 0, 0, 0);
    expect_ch(2, 1, 0, 0, 0);
    tick();
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    apply_stimulus(2, 0, 0, 0, 0, 0, 2);

    // Down count on ch3 with R = 3 from clear.
    apply_stimulus(3, 0, 1, 1, 0, 0, 3);
    expect_ch(3, 0, 0, 0, 0);
    tick();
`ifdef FLEX_CNT_DOWN_EN
    dn_seq = '{3, 2, 1, 3, 2, 1};
    term   = 1;
`else
    dn_seq = '{1, 2, 3, 1, 2, 3};
    term   = 3;
`endif
    apply_stimulus(3, 1, 0, 1, 0, 0, 3);
    for (int i = 0; i < 6; i++) begin
      expect_ch(3, dn_seq[i], dn_seq[i] == term, dn_seq[i] == term, dn_seq[i] == term);
      tick();
    end
    // Switch dir with enable low: flag re-evaluates against the up terminal.
    last = dn_seq[5];
    apply_stimulus(3, 0, 0, 0, 0, 0, 3);
    expect_ch(3, last, last == 3, 0, 0);
    tick();

    // Restart ch0 and ch2, then hit them with an asynchronous reset mid-cycle.
    apply_stimulus(0, 1, 0, 0, 0, 0, 9);
    apply_stimulus(2, 1, 0, 0, 0, 0, 2);
    expect_ch(0, 2, 0, 0, 1);
    expect_ch(2, 2, 1, 1, 1);
    tick();
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check_output("async reset count_out", count_out, 0);
    check_output("async reset flag", rollover_flag, 0);
    check_output("async reset pulse", rollover_pulse, 0);
    check_output("async reset any", any_rollover, 0);
    tick();
    n_rst = 1'b1;
    expect_ch(0, 1, 0, 0, 0);
    expect_ch(2, 1, 0, 0, 0);
    tick();

    count_enable = '0;
    tick();
    tick();
    check_output("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
